// File: rtl/gpio_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : gpio_frame_buffer
// Purpose  : Snoops processor dmem writes into a small register window,
//            assembles four 32-bit words into a 128-bit frame, queues
//            committed frames in a 2-deep FIFO and hands them to a GPIO
//            protocol block through a data_ready / write_done handshake.
// Ports    : clock        - system clock, all state on rising edge
//            reset        - synchronous active-high reset
//            address_dmem - snooped dmem word address (12 bits)
//            data         - snooped dmem write data (32 bits)
//            wren         - dmem write enable
//            write_done   - completion indication from the protocol block
//            data_ready   - frame valid toward the protocol block
//            message_out  - frame presented, word0 in [127:96]
//            status       - {29'b0, overflow, frames_pending[1:0]}
//            overflow     - sticky flag, a commit was dropped
// Window   : BASE_ADDR+0..3 staging words, +4 commit, +5 clear overflow
// Revision : 1.0 - initial release
// ============================================================================
module gpio_frame_buffer #(
    parameter logic [11:0] BASE_ADDR = 12'hFF0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [11:0]  address_dmem,
    input  logic [31:0]  data,
    input  logic         wren,
    input  logic         write_done,
    output logic         data_ready,
    output logic [127:0] message_out,
    output logic [31:0]  status,
    output logic         overflow
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SEND    = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    logic [1:0]   r_state;
    logic         r_data_ready;
    logic [127:0] r_message;
    logic         r_overflow;
    logic [1:0]   r_count;
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [31:0]  r_stage [4];
    logic [127:0] r_fifo  [2];

    logic [11:0]  w_offset;
    logic         w_hit;
    logic         w_commit;
    logic         w_clear;
    logic         w_pop;
    logic         w_full;
    logic         w_push;
    logic         w_drop;
    logic [127:0] w_frame;

    // Modulo-4096 subtraction: addresses below BASE_ADDR wrap to large
    // offsets and therefore fall outside the window.
    assign w_offset = address_dmem - BASE_ADDR;
    assign w_hit    = wren && (w_offset < 12'd6);
    assign w_commit = w_hit && (w_offset == 12'd4);
    assign w_clear  = w_hit && (w_offset == 12'd5);

    // The head leaves the FIFO on the edge where SEND samples write_done.
    assign w_pop    = (r_state == c_SEND) && write_done;
    assign w_full   = (r_count == 2'd2);
    // A simultaneous pop frees the slot the write pointer already addresses.
    assign w_push   = w_commit && (!w_full || w_pop);
    assign w_drop   = w_commit && w_full && !w_pop;
    assign w_frame  = {r_stage[0], r_stage[1], r_stage[2], r_stage[3]};

    // Staging registers, FIFO storage, pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                r_stage[k] <= 32'd0;
            end
            r_fifo[0]  <= 128'd0;
            r_fifo[1]  <= 128'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_hit && (w_offset == 12'(k))) begin
                    r_stage[k] <= data;
                end
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_frame;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Handshake FSM; message_out is captured on entry to SEND so it stays
    // stable for the whole offer and keeps the last frame once drained.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_data_ready <= 1'b0;
            r_message    <= 128'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if ((r_count != 2'd0) && !write_done) begin
                        r_message    <= r_fifo[r_rd_ptr];
                        r_data_ready <= 1'b1;
                        r_state      <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (write_done) begin
                        r_data_ready <= 1'b0;
                        r_state      <= c_RELEASE;
                    end
                end
                c_RELEASE: begin
                    if (!write_done) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_data_ready <= 1'b0;
                    r_state      <= c_IDLE;
                end
            endcase
        end
    end

    assign data_ready  = r_data_ready;
    assign message_out = r_message;
    assign overflow    = r_overflow;
    assign status      = {29'd0, r_overflow, r_count};

endmodule
`default_nettype wire

// File: tb/tb_gpio_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_frame_buffer
// Purpose  : Directed self-checking bench for gpio_frame_buffer. Committed
//            frames are queued by a small reference model and compared when
//            the DUT offers them on data_ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_frame_buffer;

    localparam logic [11:0] BASE = 12'hFF0;

    logic         clock;
    logic         reset;
    logic [11:0]  address_dmem;
    logic [31:0]  data;
    logic         wren;
    logic         write_done;
    logic         data_ready;
    logic [127:0] message_out;
    logic [31:0]  status;
    logic         overflow;

    int vectors    = 0;
    int miscompares = 0;

    logic [127:0] exp_q [$];
    logic [31:0]  m_stage [4];
    int           m_count;
    logic         m_ovf;

    gpio_frame_buffer #(.BASE_ADDR(BASE)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .write_done   (write_done),
        .data_ready   (data_ready),
        .message_out  (message_out),
        .status       (status),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_status();
        return 128'({29'd0, m_ovf, 2'(m_count)});
    endfunction

    task automatic chk_frame(input string tag);
        logic [127:0] f;
        f = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        chk(tag, message_out, f);
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        address_dmem = 12'(int'(BASE) + off);
        data         = d;
        wren         = 1'b1;
        step();
        wren         = 1'b0;
        if (off >= 0 && off < 4) m_stage[off] = d;
        if (off == 5) m_ovf = 1'b0;
    endtask

    // Commit; with pop=1 write_done is raised for the same edge.
    task automatic commit(input logic pop);
        address_dmem = BASE + 12'd4;
        data         = $urandom;
        wren         = 1'b1;
        if (pop) write_done = 1'b1;
        step();
        wren = 1'b0;
        if (m_count < 2 || pop) begin
            exp_q.push_back({m_stage[0], m_stage[1], m_stage[2], m_stage[3]});
            m_count = m_count + 1 - int'(pop);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int k = 0; k < 4; k++) m_stage[k] = 32'd0;
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset wins over a simultaneous write and write_done
        reset = 1'b1; wren = 1'b1; address_dmem = BASE; data = 32'hFFFF_FFFF;
        write_done = 1'b1;
        step(); step();
        reset = 1'b0; wren = 1'b0; write_done = 1'b0;
        chk("rst_data_ready", 128'(data_ready), 128'(1'b0));
        chk("rst_status", 128'(status), 128'd0);
        chk("rst_message", message_out, 128'd0);
        chk("rst_overflow", 128'(overflow), 128'(1'b0));

        // Basic frame and 2-cycle latency
        wr(0, 32'h0000_0156); wr(1, 32'd3145); wr(2, 32'd29455); wr(3, 32'd939415);
        commit(1'b0);
        chk("lat1_data_ready", 128'(data_ready), 128'(1'b0));
        chk("lat1_status", 128'(status), exp_status());
        step();
        chk("lat2_data_ready", 128'(data_ready), 128'(1'b1));
        chk("frame0_literal", message_out, {32'h156, 32'd3145, 32'd29455, 32'd939415});
        chk_frame("frame0_sb");

        // write_done held three cycles
        write_done = 1'b1;
        step();
        m_count = m_count - 1;
        chk("hs_fall_data_ready", 128'(data_ready), 128'(1'b0));
        chk("hs_fall_status", 128'(status), exp_status());
        step();
        chk("hs_hold1_data_ready", 128'(data_ready), 128'(1'b0));
        step();
        chk("hs_hold2_data_ready", 128'(data_ready), 128'(1'b0));
        write_done = 1'b0;
        step();
        chk("hs_idle_data_ready", 128'(data_ready), 128'(1'b0));
        chk("hold_last_frame", message_out, {32'h156, 32'd3145, 32'd29455, 32'd939415});

        // Out-of-window and non-write accesses have no effect
        wr(6, 32'hDEAD_0006);
        wr(-1, 32'hDEAD_FFFF);
        address_dmem = BASE + 12'd4; data = 32'h1234_5678; wren = 1'b0;
        step();
        chk("ign_status", 128'(status), exp_status());
        step();
        chk("ign_data_ready", 128'(data_ready), 128'(1'b0));

        // Three commits without a handshake: third is dropped
        commit(1'b0);                       // frame A (unchanged staging)
        wr(0, 32'hA5A5_0002);
        commit(1'b0);                       // frame B
        wr(0, 32'hA5A5_0003);
        commit(1'b0);                       // dropped
        chk("ovf_status", 128'(status), exp_status());
        chk("ovf_status_lit", 128'(status), 128'h6);
        chk("ovf_flag", 128'(overflow), 128'(1'b1));
        chk("ovf_data_ready", 128'(data_ready), 128'(1'b1));
        chk_frame("frameA");
        wr(5, 32'hFFFF_FFFF);
        chk("clr_status", 128'(status), 128'h2);
        chk("clr_flag", 128'(overflow), 128'(1'b0));

        // Full FIFO, commit coincides with pop
        wr(0, 32'hA5A5_0004);
        commit(1'b1);                       // pops A, pushes D
        write_done = 1'b0;
        chk("cp_full_overflow", 128'(overflow), 128'(1'b0));
        chk("cp_full_status", 128'(status), exp_status());
        chk("cp_full_data_ready", 128'(data_ready), 128'(1'b0));
        step();
        chk("gap1_data_ready", 128'(data_ready), 128'(1'b0));
        step();
        chk("frameB_data_ready", 128'(data_ready), 128'(1'b1));
        chk_frame("frameB");
        write_done = 1'b1;
        step();
        m_count = m_count - 1;
        write_done = 1'b0;
        chk("popB_status", 128'(status), exp_status());
        step(); step();
        chk("frameD_data_ready", 128'(data_ready), 128'(1'b1));
        chk_frame("frameD");

        // Commit and pop with one frame pending: new frame becomes head
        wr(0, 32'hA5A5_0005);
        commit(1'b1);                       // pops D, pushes E
        write_done = 1'b0;
        chk("cp_one_status", 128'(status), exp_status());
        chk("cp_one_status_lit", 128'(status), 128'h1);
        step(); step();
        chk("frameE_data_ready", 128'(data_ready), 128'(1'b1));
        chk_frame("frameE");
        write_done = 1'b1;
        step();
        m_count = m_count - 1;
        write_done = 1'b0;
        step(); step();
        chk("drained_status", 128'(status), exp_status());
        chk("drained_data_ready", 128'(data_ready), 128'(1'b0));

        // Reset during SEND with two frames pending
        wr(1, 32'h0BAD_F00D);
        commit(1'b0);
        commit(1'b0);
        chk("pre_rst_status", 128'(status), 128'h2);
        chk("pre_rst_data_ready", 128'(data_ready), 128'(1'b1));
        chk_frame("frameF");
        reset = 1'b1; write_done = 1'b1;
        address_dmem = BASE + 12'd4; wren = 1'b1;
        step();
        reset = 1'b0; write_done = 1'b0; wren = 1'b0;
        model_reset();
        chk("midrst_data_ready", 128'(data_ready), 128'(1'b0));
        chk("midrst_status", 128'(status), 128'd0);
        chk("midrst_message", message_out, 128'd0);
        step(); step();
        chk("postrst_data_ready", 128'(data_ready), 128'(1'b0));
        commit(1'b0);                       // staging was cleared
        step();
        chk("postrst_frame_dr", 128'(data_ready), 128'(1'b1));
        chk_frame("postrst_frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
